// File: rtl/div_clk_checker.sv
// Self-check monitor for a divided-clock square wave: measures period and high time,
// compares against the expected shape, and reports lock and stall status.
module div_clk_checker #(
  parameter int CNT_W       = 8,
  parameter int EXP_PERIOD  = 8,
  parameter int EXP_HIGH    = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_in_i,
  output logic             valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             err_o,
  output logic             locked_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_STALLED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] EXP_PERIOD_C = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_HIGH_C   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TO_LAST_C    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HI_MAX_C     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [1:0]       match_cnt_q, match_cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic             rise_s;
  logic             level_s;
  logic [CNT_W-1:0] per_inc_s;
  logic [CNT_W-1:0] hi_inc_s;
  logic             match_s;

  // sync_q[1] is the synchronised level, sync_q[2] its one-cycle-old copy
  assign level_s   = sync_q[1];
  assign rise_s    = sync_q[1] & ~sync_q[2];
  assign per_inc_s = per_cnt_q + ONE_C;
  assign hi_inc_s  = (hi_cnt_q == HI_MAX_C) ? hi_cnt_q : hi_cnt_q + ONE_C;
  assign match_s   = (per_inc_s == EXP_PERIOD_C) && (hi_cnt_q == EXP_HIGH_C);

  always_comb begin
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    match_cnt_d = match_cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    period_d    = period_q;
    high_d      = high_q;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d   = ST_MEASURE;
          per_cnt_d = '0;
          hi_cnt_d  = ONE_C;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        // A rise takes priority over a timeout landing on the same cycle
        if (rise_s) begin
          valid_d   = 1'b1;
          period_d  = per_inc_s;
          high_d    = hi_cnt_q;
          per_cnt_d = '0;
          hi_cnt_d  = ONE_C;
          if (match_s) begin
            match_cnt_d = (match_cnt_q == 2'd2) ? 2'd2 : match_cnt_q + 2'd1;
            locked_d    = (match_cnt_d == 2'd2);
          end else begin
            err_d       = 1'b1;
            match_cnt_d = 2'd0;
            locked_d    = 1'b0;
          end
        end else if (per_cnt_q == TO_LAST_C) begin
          state_d     = ST_STALLED;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = 2'd0;
        end else begin
          per_cnt_d = per_inc_s;
          if (level_s) begin
            hi_cnt_d = hi_inc_s;
          end else begin
            hi_cnt_d = hi_cnt_q;
          end
        end
      end
      ST_STALLED: begin
        if (rise_s) begin
          state_d   = ST_MEASURE;
          timeout_d = 1'b0;
          per_cnt_d = '0;
          hi_cnt_d  = ONE_C;
        end else begin
          state_d = ST_STALLED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sync_q      <= 3'b000;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      match_cnt_q <= 2'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[1:0], div_in_i};
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      match_cnt_q <= match_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      period_q    <= period_d;
      high_q      <= high_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign period_o    = period_q;
  assign high_time_o = high_q;
  assign locked_o    = locked_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_div_clk_checker.sv
// Directed bench for div_clk_checker: good /8 wave, shape errors, stall, reset, async input.
module tb_div_clk_checker;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       div_in_i;
  logic       valid_o;
  logic [7:0] period_o;
  logic [7:0] high_time_o;
  logic       err_o;
  logic       locked_o;
  logic       timeout_o;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_valid_cyc = 0;
  int vcount, ecount;
  logic [31:0] cap_period, cap_high, cap_err, cap_locked;
  int nv;
  int to_cnt;

  div_clk_checker #(
    .CNT_W(8), .EXP_PERIOD(8), .EXP_HIGH(4), .TIMEOUT_CYC(255)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .div_in_i    (div_in_i),
    .valid_o     (valid_o),
    .period_o    (period_o),
    .high_time_o (high_time_o),
    .err_o       (err_o),
    .locked_o    (locked_o),
    .timeout_o   (timeout_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  // One period of the wave, high first; captures any VALID strobe seen in the window
  task automatic run_period(input int hi, input int lo);
    vcount = 0;
    ecount = 0;
    for (int i = 0; i < hi + lo; i++) begin
      div_in_i = (i < hi);
      tick();
      if (err_o) ecount++;
      if (valid_o) begin
        vcount++;
        cap_period = 32'(period_o);
        cap_high   = 32'(high_time_o);
        cap_err    = 32'(err_o);
        cap_locked = 32'(locked_o);
        last_valid_cyc = cyc;
      end
    end
  endtask

  task automatic chk_meas(input string tag, input int per, input int hi, input int er, input int lk);
    chk({tag, "_vcount"}, 32'(vcount), 32'd1);
    chk({tag, "_period"}, cap_period, 32'(per));
    chk({tag, "_high"},   cap_high,   32'(hi));
    chk({tag, "_err"},    cap_err,    32'(er));
    chk({tag, "_ecount"}, 32'(ecount), 32'(er));
    chk({tag, "_locked"}, cap_locked, 32'(lk));
  endtask

  initial begin
    rst_i    = 1'b1;
    div_in_i = 1'b0;
    #1;
    chk("rst_valid",   32'(valid_o),     32'd0);
    chk("rst_period",  32'(period_o),    32'd0);
    chk("rst_high",    32'(high_time_o), 32'd0);
    chk("rst_flags",   32'({err_o, locked_o, timeout_o}), 32'd0);
    tick(); tick();
    rst_i = 1'b0;

    // 1: clean /8 wave
    run_period(4, 4);
    chk("t1_first_rise_novalid", 32'(vcount), 32'd0);
    run_period(4, 4);
    chk_meas("t1_v1", 8, 4, 0, 0);
    run_period(4, 4);
    chk_meas("t1_v2", 8, 4, 0, 1);
    run_period(4, 4);
    chk_meas("t1_v3", 8, 4, 0, 1);

    // 2: one short-high period while locked
    run_period(3, 5);
    chk_meas("t2_prev", 8, 4, 0, 1);
    run_period(4, 4);
    chk_meas("t2_bad", 8, 3, 1, 0);
    chk("t2_locked_now", 32'(locked_o), 32'd0);
    run_period(4, 4);
    chk_meas("t2_good1", 8, 4, 0, 0);
    run_period(4, 4);
    chk_meas("t2_good2", 8, 4, 0, 1);

    // 3: input stops low while locked
    to_cnt = 0;
    while (!timeout_o && to_cnt < 400) begin
      div_in_i = 1'b0;
      tick();
      to_cnt++;
    end
    chk("t3_timeout_seen", 32'(timeout_o), 32'd1);
    chk("t3_timeout_delay", 32'(cyc - last_valid_cyc), 32'd255);
    chk("t3_locked", 32'(locked_o), 32'd0);
    chk("t3_period_hold", 32'(period_o), 32'd8);
    chk("t3_high_hold", 32'(high_time_o), 32'd4);
    run_period(4, 4);
    chk("t3_restart_novalid", 32'(vcount), 32'd0);
    chk("t3_timeout_clr", 32'(timeout_o), 32'd0);
    run_period(4, 4);
    chk_meas("t3_after", 8, 4, 0, 0);

    // 4: period 12 (6/6)
    run_period(6, 6);
    chk_meas("t4_prev", 8, 4, 0, 1);
    run_period(6, 6);
    chk_meas("t4_v1", 12, 6, 1, 0);
    run_period(4, 4);
    chk_meas("t4_v2", 12, 6, 1, 0);

    // 5: reset mid-period while locked
    run_period(4, 4);
    chk_meas("t5_pre1", 8, 4, 0, 0);
    run_period(4, 4);
    chk_meas("t5_pre2", 8, 4, 0, 1);
    div_in_i = 1'b1;
    tick(); tick();
    #2;
    rst_i = 1'b1;
    #1;
    chk("t5_async_period", 32'(period_o), 32'd0);
    chk("t5_async_high", 32'(high_time_o), 32'd0);
    chk("t5_async_flags", 32'({valid_o, err_o, locked_o, timeout_o}), 32'd0);
    div_in_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b0;
    run_period(4, 4);
    chk("t5_first_rise_novalid", 32'(vcount), 32'd0);
    run_period(4, 4);
    chk_meas("t5_v1", 8, 4, 0, 0);
    run_period(4, 4);
    chk_meas("t5_v2", 8, 4, 0, 1);

    // 6: free-running asynchronous input, period 166 time units = 8.3 clocks
    nv = 0;
    fork
      begin
        repeat (60) begin
          #83;
          div_in_i = ~div_in_i;
        end
      end
      begin
        repeat (240) begin
          tick();
          if (valid_o) begin
            nv++;
            if (nv > 2) begin
              chk("t6_no_x", 32'($isunknown({valid_o, period_o, high_time_o, err_o, locked_o, timeout_o})), 32'd0);
              chk("t6_period_range", 32'((period_o == 8'd8) || (period_o == 8'd9)), 32'd1);
              chk("t6_high_range", 32'(((2 * int'(high_time_o)) - int'(period_o) <= 2) &&
                                       (int'(period_o) - (2 * int'(high_time_o)) <= 2)), 32'd1);
              chk("t6_timeout", 32'(timeout_o), 32'd0);
            end
          end
        end
      end
    join
    chk("t6_valid_count", 32'(nv >= 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
